// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared types for the odd-even transposition relaxation array
package bf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_t;

endpackage

// File: rtl/bf_cx_cell.sv
// rtl/bf_cx_cell.sv - combinational compare-exchange of two (dist, tag) pairs
module bf_cx_cell #(
  parameter int W  = 32,
  parameter int TW = 8
) (
  input  logic          en,
  input  logic [W-1:0]  a_dist,
  input  logic [TW-1:0] a_tag,
  input  logic [W-1:0]  b_dist,
  input  logic [TW-1:0] b_tag,
  output logic [W-1:0]  lo_dist,
  output logic [TW-1:0] lo_tag,
  output logic [W-1:0]  hi_dist,
  output logic [TW-1:0] hi_tag,
  output logic          xchg
);

  // strict compare keeps equal keys in place, which makes the sort stable
  assign xchg    = en && (a_dist > b_dist);
  assign lo_dist = xchg ? b_dist : a_dist;
  assign lo_tag  = xchg ? b_tag  : a_tag;
  assign hi_dist = xchg ? a_dist : b_dist;
  assign hi_tag  = xchg ? a_tag  : b_tag;

endmodule

// File: rtl/bf_oet_relax_array.sv
// rtl/bf_oet_relax_array.sv - N-lane odd-even transposition sorter with early exit and abort
module bf_oet_relax_array
  import bf_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = 32,
  parameter int TW = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic            clk,
  input  logic            rst_global,
  input  logic            start,
  input  logic            abort,
  input  logic [N*W-1:0]  din_dist,
  input  logic [N*TW-1:0] din_tag,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            early_exit,
  output logic [CW-1:0]   phase_count,
  output logic [N*W-1:0]  dout_dist,
  output logic [N*TW-1:0] dout_tag
);

  state_t        r_state, w_state_nxt;
  parity_t       r_parity;
  logic          r_quiet;
  logic          r_done;
  logic          r_early;
  logic [CW-1:0] r_pc;
  logic [W-1:0]  r_dist [N];
  logic [TW-1:0] r_tag  [N];

  logic [W-1:0]  w_ev_dist [N];
  logic [TW-1:0] w_ev_tag  [N];
  logic [W-1:0]  w_od_dist [N];
  logic [TW-1:0] w_od_tag  [N];
  logic [N/2-1:0] w_ev_x;
  logic [N/2-1:0] w_od_x;
  logic          w_ev_en, w_od_en;
  logic          w_quiet_now;
  logic [CW-1:0] w_pc_nxt;
  logic          w_exit;
  logic          w_load, w_step, w_finish;

  assign w_ev_en = (r_parity == EVEN);
  assign w_od_en = (r_parity == ODD);

  genvar g;
  generate
    for (g = 0; g < N/2; g++) begin : g_even
      bf_cx_cell #(.W(W), .TW(TW)) u_cx (
        .en      (w_ev_en),
        .a_dist  (r_dist[2*g]),
        .a_tag   (r_tag[2*g]),
        .b_dist  (r_dist[2*g+1]),
        .b_tag   (r_tag[2*g+1]),
        .lo_dist (w_ev_dist[2*g]),
        .lo_tag  (w_ev_tag[2*g]),
        .hi_dist (w_ev_dist[2*g+1]),
        .hi_tag  (w_ev_tag[2*g+1]),
        .xchg    (w_ev_x[g])
      );
    end

    for (g = 0; g < N/2-1; g++) begin : g_odd
      bf_cx_cell #(.W(W), .TW(TW)) u_cx (
        .en      (w_od_en),
        .a_dist  (r_dist[2*g+1]),
        .a_tag   (r_tag[2*g+1]),
        .b_dist  (r_dist[2*g+2]),
        .b_tag   (r_tag[2*g+2]),
        .lo_dist (w_od_dist[2*g+1]),
        .lo_tag  (w_od_tag[2*g+1]),
        .hi_dist (w_od_dist[2*g+2]),
        .hi_tag  (w_od_tag[2*g+2]),
        .xchg    (w_od_x[g])
      );
    end

    // end lanes sit out the odd phase; the spare flag bit keeps N=2 legal
    assign w_od_dist[0]   = r_dist[0];
    assign w_od_tag[0]    = r_tag[0];
    assign w_od_dist[N-1] = r_dist[N-1];
    assign w_od_tag[N-1]  = r_tag[N-1];
    assign w_od_x[N/2-1]  = 1'b0;

    for (g = 0; g < N; g++) begin : g_out
      assign dout_dist[g*W +: W]   = r_dist[g];
      assign dout_tag[g*TW +: TW]  = r_tag[g];
    end
  endgenerate

  assign w_quiet_now = ~(|w_ev_x | |w_od_x);
  assign w_pc_nxt    = r_pc + CW'(1);
  assign w_exit      = (w_quiet_now && r_quiet && (w_pc_nxt >= CW'(2))) ||
                       (w_pc_nxt == CW'(N));

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else if (start) begin
          w_load      = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
          if (w_exit) begin
            w_finish    = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst_global) begin
    if (rst_global) begin
      r_parity <= EVEN;
      r_quiet  <= 1'b0;
      r_done   <= 1'b0;
      r_early  <= 1'b0;
      r_pc     <= '0;
      for (int i = 0; i < N; i++) begin
        r_dist[i] <= '0;
        r_tag[i]  <= '0;
      end
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_parity <= EVEN;
        r_quiet  <= 1'b0;
        r_early  <= 1'b0;
        r_pc     <= '0;
        for (int i = 0; i < N; i++) begin
          r_dist[i] <= din_dist[i*W +: W];
          r_tag[i]  <= din_tag[i*TW +: TW];
        end
      end else if (w_step) begin
        r_parity <= (r_parity == EVEN) ? ODD : EVEN;
        r_quiet  <= w_quiet_now;
        r_pc     <= w_pc_nxt;
        if (w_exit) r_early <= (w_pc_nxt != CW'(N));
        for (int i = 0; i < N; i++) begin
          r_dist[i] <= w_ev_en ? w_ev_dist[i] : w_od_dist[i];
          r_tag[i]  <= w_ev_en ? w_ev_tag[i]  : w_od_tag[i];
        end
      end
    end
  end

  assign ready       = (r_state != RUN);
  assign busy        = (r_state == RUN);
  assign done        = r_done;
  assign early_exit  = r_early;
  assign phase_count = r_pc;

endmodule
